// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: round-robin arbiter in front of a shared N:1 one-hot AND-OR mux.
//   clk           rising-edge clock
//   reset_n       asynchronous active-low reset
//   req_valid_i   per-requester valid
//   req_data_i    packed requester data, requester k at [k*DATA_W +: DATA_W]
//   req_ready_o   per-requester ready (only the granted requester, gated by out_ready_i)
//   out_valid_o   shared output valid
//   out_data_o    shared output data (zero when nothing is granted)
//   out_ready_i   downstream ready
//   gnt_o         registered one-hot grant, all-zero when idle
// Optional feature macro ARB_PKT_LOCK_EN adds req_last_i / out_last_o and locks the
// grant to one requester until the beat flagged last is transferred.
module rr_mux_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
`ifdef ARB_PKT_LOCK_EN
  input  logic [NUM_REQ-1:0]        req_last_i,
  output logic                      out_last_o,
`endif
  output logic [NUM_REQ-1:0]        req_ready_o,
  output logic                      out_valid_o,
  output logic [DATA_W-1:0]         out_data_o,
  input  logic                      out_ready_i,
  output logic [NUM_REQ-1:0]        gnt_o
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);
  localparam logic [PTR_W:0] NUM_REQ_P = (PTR_W+1)'(NUM_REQ);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e               state_q, state_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;

  logic                 g_valid;
  logic                 g_last;
  logic                 xfer;
  logic [PTR_W-1:0]     g_idx;
  logic [PTR_W-1:0]     g_inc;
  logic [DATA_W-1:0]    data_mux;

  // (ptr + off) mod NUM_REQ; one extra bit of headroom keeps the sum from overflowing
  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] ptr,
                                                input logic [PTR_W:0]   off);
    logic [PTR_W:0] sum;
    sum = {1'b0, ptr} + off;
    if (sum >= NUM_REQ_P) sum = sum - NUM_REQ_P;
    return sum[PTR_W-1:0];
  endfunction

  // One-hot of the first set bit of vec, searching upward from ptr with wrap; zero if none
  function automatic logic [NUM_REQ-1:0] pick(input logic [PTR_W-1:0]   ptr,
                                              input logic [NUM_REQ-1:0] vec);
    logic [NUM_REQ-1:0] oh;
    logic [PTR_W-1:0]   idx;
    logic               found;
    oh    = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = wrap_add(ptr, (PTR_W+1)'(i));
      if (!found && vec[idx]) begin
        oh[idx] = 1'b1;
        found   = 1'b1;
      end
    end
    return oh;
  endfunction

  // Grant is one-hot, so OR-ing the indices of set bits yields the granted index
  function automatic logic [PTR_W-1:0] oh2idx(input logic [NUM_REQ-1:0] oh);
    logic [PTR_W-1:0] idx;
    idx = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (oh[k]) idx = idx | PTR_W'(k);
    end
    return idx;
  endfunction

  // AND-OR datapath mux steered by the registered grant
  always_comb begin
    data_mux = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      data_mux = data_mux | (req_data_i[k*DATA_W +: DATA_W] & {DATA_W{gnt_q[k]}});
    end
  end

  assign g_valid = |(gnt_q & req_valid_i);
  assign g_idx   = oh2idx(gnt_q);
  assign g_inc   = wrap_add(g_idx, (PTR_W+1)'(1));
  assign xfer    = g_valid && out_ready_i;

`ifdef ARB_PKT_LOCK_EN
  assign g_last     = |(gnt_q & req_last_i);
  assign out_last_o = g_last;
`else
  assign g_last     = 1'b1;
`endif

  // Outputs follow the grant register, so reset clears them asynchronously
  assign gnt_o       = gnt_q;
  assign out_valid_o = g_valid;
  assign out_data_o  = data_mux;
  assign req_ready_o = gnt_q & {NUM_REQ{out_ready_i}};

  // State, grant and pointer registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
    end
  end

  // Next-state: arbitrate from IDLE, rotate on a completed transfer, re-arbitrate on withdrawal
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (|req_valid_i) begin
          gnt_d   = pick(ptr_q, req_valid_i);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (!g_valid) begin
          gnt_d   = pick(ptr_q, req_valid_i);
          state_d = (|req_valid_i) ? BUSY : IDLE;
        end else if (xfer && g_last) begin
          ptr_d   = g_inc;
          gnt_d   = pick(g_inc, req_valid_i);
          state_d = (|req_valid_i) ? BUSY : IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed self-checking bench for rr_mux_arbiter (NUM_REQ=4, DATA_W=8).
module tb_rr_mux_arbiter;

  logic        clk;
  logic        reset_n;
  logic [3:0]  req_valid_i;
  logic [31:0] req_data_i;
  logic [3:0]  req_ready_o;
  logic        out_valid_o;
  logic [7:0]  out_data_o;
  logic        out_ready_i;
  logic [3:0]  gnt_o;
`ifdef ARB_PKT_LOCK_EN
  logic [3:0]  req_last_i;
  logic        out_last_o;
`endif

  int passed = 0;
  int failed = 0;
  int total  = 0;

  rr_mux_arbiter #(.NUM_REQ(4), .DATA_W(8)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid_i (req_valid_i),
    .req_data_i  (req_data_i),
`ifdef ARB_PKT_LOCK_EN
    .req_last_i  (req_last_i),
    .out_last_o  (out_last_o),
`endif
    .req_ready_o (req_ready_o),
    .out_valid_o (out_valid_o),
    .out_data_o  (out_data_o),
    .out_ready_i (out_ready_i),
    .gnt_o       (gnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] g, input logic v,
                         input logic [3:0] r, input logic [7:0] d);
    chk({tag, ".gnt"},   32'(gnt_o),       32'(g));
    chk({tag, ".valid"}, 32'(out_valid_o), 32'(v));
    chk({tag, ".ready"}, 32'(req_ready_o), 32'(r));
    chk({tag, ".data"},  32'(out_data_o),  32'(d));
  endtask

  initial begin
    reset_n     = 1'b1;
    req_valid_i = 4'b0000;
    req_data_i  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    out_ready_i = 1'b1;
`ifdef ARB_PKT_LOCK_EN
    req_last_i  = 4'b0000;
`endif
    #1;
    reset_n     = 1'b0;
    req_valid_i = 4'b1111;
    #2;
    chk_out("rst", 4'b0000, 1'b0, 4'b0000, 8'h00);
    tick();
    chk_out("rst_hold", 4'b0000, 1'b0, 4'b0000, 8'h00);
    reset_n = 1'b1;
    #1;
    chk_out("rst_rel", 4'b0000, 1'b0, 4'b0000, 8'h00);
    tick();
    chk_out("first", 4'b0001, 1'b1, 4'b0001, 8'hA0);

    // Rotation: all valid, ready high, one transfer per cycle
    for (int i = 0; i < 8; i++) begin
      chk_out("rot", 4'(1 << (i % 4)), 1'b1, 4'(1 << (i % 4)), 8'(8'hA0 + i % 4));
      tick();
    end
    chk_out("rot_wrap", 4'b0001, 1'b1, 4'b0001, 8'hA0);

    // Move grant to requester 2, then stall with requester 0 also pending
    tick();
    tick();
    req_valid_i = 4'b0101;
    out_ready_i = 1'b0;
    #1;
    chk_out("stall0", 4'b0100, 1'b1, 4'b0000, 8'hA2);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out("stall", 4'b0100, 1'b1, 4'b0000, 8'hA2);
    end
    out_ready_i = 1'b1;
    #1;
    chk_out("stall_rel", 4'b0100, 1'b1, 4'b0100, 8'hA2);
    tick();
    chk_out("wrap0", 4'b0001, 1'b1, 4'b0001, 8'hA0);

    // Sparse: only requester 3, then nothing, then requester 1 from idle
    req_valid_i = 4'b1000;
    #1;
    chk_out("sp_drop", 4'b0001, 1'b0, 4'b0001, 8'hA0);
    tick();
    chk_out("sp3", 4'b1000, 1'b1, 4'b1000, 8'hA3);
    tick();
    req_valid_i = 4'b0000;
    #1;
    chk_out("sp3_after", 4'b1000, 1'b0, 4'b1000, 8'hA3);
    tick();
    chk_out("idle", 4'b0000, 1'b0, 4'b0000, 8'h00);
    req_valid_i = 4'b0010;
    tick();
    chk_out("sp1", 4'b0010, 1'b1, 4'b0010, 8'hA1);

    // Withdrawal without transfer: pointer stays 0, so requester 0 beats requester 3
    req_valid_i = 4'b1001;
    out_ready_i = 1'b0;
    #1;
    chk_out("wd_pre", 4'b0010, 1'b0, 4'b0000, 8'hA1);
    tick();
    chk_out("wd_regrant", 4'b0001, 1'b1, 4'b0000, 8'hA0);
    out_ready_i = 1'b1;
    tick();
    chk_out("pre_rst", 4'b1000, 1'b1, 4'b1000, 8'hA3);

    // Asynchronous reset during BUSY; pointer must restart at 0
    #2;
    reset_n = 1'b0;
    #1;
    chk_out("rst_async", 4'b0000, 1'b0, 4'b0000, 8'h00);
    tick();
    reset_n = 1'b1;
    tick();
    chk_out("post_rst", 4'b0001, 1'b1, 4'b0001, 8'hA0);

`ifdef ARB_PKT_LOCK_EN
    // Three-beat packet from requester 0 with requester 1 pending throughout
    req_valid_i = 4'b0011;
    req_last_i  = 4'b0000;
    #1;
    chk("pkt_b1.gnt", 32'(gnt_o), 32'h1);
    chk("pkt_b1.last", 32'(out_last_o), 32'h0);
    tick();
    chk("pkt_b2.gnt", 32'(gnt_o), 32'h1);
    tick();
    req_last_i = 4'b0001;
    #1;
    chk("pkt_b3.gnt", 32'(gnt_o), 32'h1);
    chk("pkt_b3.last", 32'(out_last_o), 32'h1);
    tick();
    chk("pkt_next.gnt", 32'(gnt_o), 32'h2);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
